i2c_reg_master: RTL and testbench



---
 rtl/i2c_reg_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-byte I2C register read/write master.
//
// Write: START, {dev,0}+A, reg+A, wdata+A, STOP.
// Read : START, {dev,0}+A, reg+A, Sr, {dev,1}+A, 8 rx bits, NACK, STOP.
// A NACK at any ACK sample aborts straight to STOP and sets ack_err.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, rw             request pulse (sampled when idle), 0=write 1=read
//   dev_addr, reg_addr    7-bit slave address, register index
//   wdata                 write data byte
//   busy, done            transaction in progress, one-cycle end pulse
//   ack_err               last transaction aborted by NACK
//   rdata                 last successfully read byte
//   scl                   push-pull I2C clock
//   sda_in, sda_out, sda_oe  open-drain SDA (sda_oe=1 pulls low)
//
// state      | meaning
// S_IDLE     | bus idle, waiting for start
// S_START    | START condition, 2 quarters
// S_BIT      | one 4-quarter bit slot (slots 0..7 data, slot 8 ACK)
// S_REPSTART | repeated START, 4 quarters
// S_STOP     | STOP condition, 4 quarters
module i2c_reg_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_REPSTART, S_STOP
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [3:0]  slot_q, slot_d;
  logic [1:0]  byte_q, byte_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;

  logic        tick;
  logic        is_rx_q, is_rx_d;
  logic [7:0]  tbyte_d;
  logic        tbit_d;

  // Byte 3 only exists in a read and is the one byte the master receives.
  assign tick    = busy_q && (cnt_q == CNT_LAST);
  assign is_rx_q = rw_q && (byte_q == 2'd3);

  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic rw_b,
                                         input logic [6:0] dev, input logic [7:0] ra,
                                         input logic [7:0] wd);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = ra;
      2'd2:    b = rw_b ? {dev, 1'b1} : wd;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    slot_d    = slot_q;
    byte_d    = byte_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;

    if (state_q == S_IDLE) begin
      if (start) begin
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        wdata_d   = wdata;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
        cnt_d     = '0;
        qtr_d     = 2'd0;
        state_d   = S_START;
      end
    end else if (!tick) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        S_START: begin
          if (qtr_q == 2'd1) begin
            state_d = S_BIT;
            qtr_d   = 2'd0;
            slot_d  = 4'd0;
            byte_d  = 2'd0;
          end
        end
        S_BIT: begin
          // Sample on the tick ending Q1 (middle of SCL high).
          if (qtr_q == 2'd1) begin
            if (slot_q == 4'd8) begin
              if (!is_rx_q && sda_in) ack_err_d = 1'b1;
            end else if (is_rx_q) begin
              rx_d = {rx_q[6:0], sda_in};
            end
          end
          if (qtr_q == 2'd3) begin
            if (is_rx_q && slot_q == 4'd7) rdata_d = rx_q;
            if (slot_q != 4'd8) begin
              slot_d = slot_q + 4'd1;
            end else begin
              slot_d = 4'd0;
              if (ack_err_q || is_rx_q)          state_d = S_STOP;
              else if (byte_q == 2'd1 && rw_q)   state_d = S_REPSTART;
              else if (byte_q == 2'd2 && !rw_q)  state_d = S_STOP;
              else                               byte_d  = byte_q + 2'd1;
            end
          end
        end
        S_REPSTART: begin
          if (qtr_q == 2'd3) begin
            state_d = S_BIT;
            slot_d  = 4'd0;
            byte_d  = 2'd2;
          end
        end
        S_STOP: begin
          if (qtr_q == 2'd3) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Line levels are derived from the next state so they are registered
  // and change on the same edge the quarter begins.
  always_comb begin
    is_rx_d = rw_d && (byte_d == 2'd3);
    tbyte_d = tx_byte(byte_d, rw_d, dev_d, reg_d, wdata_d);
    tbit_d  = tbyte_d[3'd7 - slot_d[2:0]];
    scl_d   = 1'b1;
    oe_d    = 1'b0;
    case (state_d)
      S_START: begin
        scl_d = (qtr_d == 2'd0);
        oe_d  = 1'b1;
      end
      S_BIT: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        oe_d  = (slot_d < 4'd8) && !is_rx_d && !tbit_d;
      end
      S_REPSTART: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        oe_d  = (qtr_d >= 2'd2);
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        oe_d  = (qtr_d < 2'd2);
      end
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      qtr_q     <= 2'd0;
      slot_q    <= 4'd0;
      byte_q    <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rdata_q   <= 8'h00;
      rx_q      <= 8'h00;
      rw_q      <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      scl_q     <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      slot_q    <= slot_d;
      byte_q    <= byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rdata_q   <= rdata_d;
      rx_q      <= rx_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      scl_q     <= scl_d;
      oe_q      <= oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;
  assign scl     = scl_q;
  assign sda_oe  = oe_q;
  assign sda_out = 1'b0;

endmodule

// File: tb/tb_i2c_reg_master.sv
module tb_i2c_reg_master;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] SLV_ADDR = 7'h28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, ack_err, scl, sda_in, sda_out, sda_oe;
  logic [7:0] rdata;

  logic       slave_low = 1'b0;
  bit         slave_present = 1'b1;
  logic [7:0] txd = 8'hA5;

  assign sda_in = !(sda_oe || slave_low);

  i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata),
    .scl(scl), .sda_in(sda_in), .sda_out(sda_out), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int both_high = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural slave / bus monitor ----------------
  logic [7:0] got[$];
  int         n_starts, n_stops;
  logic       master_ack;
  logic [7:0] sh;
  int         bitc, mode, byte_cnt;
  bit         acked, addressed, read_mode;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;

  // mode: 0 ignore, 1 receiving, 2 driving ACK, 3 sending data, 4 master ack slot
  always @(negedge clk) begin
    logic cur_sda;
    cur_sda = sda_in;
    if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && cur_sda === 1'b0) begin
      n_starts++; mode = 1; bitc = 0; byte_cnt = 0; slave_low = 1'b0;
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && cur_sda === 1'b1) begin
      n_stops++; mode = 0; slave_low = 1'b0;
    end else if (prev_scl === 1'b0 && scl === 1'b1) begin
      if (mode == 1 && bitc < 8) begin
        sh = {sh[6:0], cur_sda};
        bitc++;
      end else if (mode == 4) begin
        master_ack = cur_sda;
      end
    end else if (prev_scl === 1'b1 && scl === 1'b0) begin
      case (mode)
        1: if (bitc == 8) begin
          got.push_back(sh);
          if (byte_cnt == 0) begin
            addressed = slave_present && (sh[7:1] == SLV_ADDR);
            read_mode = sh[0];
          end
          acked = addressed;
          byte_cnt++;
          slave_low = acked;
          mode = 2;
        end
        2: begin
          slave_low = 1'b0;
          if (!acked) mode = 0;
          else if (read_mode) begin
            slave_low = !txd[7];
            bitc = 1;
            mode = 3;
          end else begin
            mode = 1;
            bitc = 0;
          end
        end
        3: if (bitc < 8) begin
          slave_low = !txd[7 - bitc];
          bitc++;
        end else begin
          slave_low = 1'b0;
          mode = 4;
        end
        4: mode = 0;
        default: ;
      endcase
    end
    prev_scl = scl;
    prev_sda = !(sda_oe || slave_low);
  end

  // ---------------- helpers ----------------
  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] wd, input int mid_at,
                         output int busy_cyc, output int done_cnt);
    got.delete();
    n_starts = 0;
    n_stops = 0;
    master_ack = 1'b0;
    @(negedge clk);
    rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (done && busy) both_high++;
      if (i == mid_at) begin
        start = 1'b1; rw = 1'b0; dev_addr = 7'h11; reg_addr = 8'h22; wdata = 8'h33;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", {31'd0, done}, 32'd1);
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done && busy) both_high++;
    end
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    chk({tag, "_nbytes"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, e[8*(n-1-i) +: 8]});
  endtask

  int bc, dc;

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("sda_out", {31'd0, sda_out}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_scl", {31'd0, scl}, 32'd1);
    chk("post_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // register write
    slave_present = 1'b1;
    run_txn(1'b0, 7'h28, 8'h03, 8'h5A, -1, bc, dc);
    check_bytes("wr", 3, 32'h0050035A);
    chk("wr_busy_cycles", bc, 456);
    chk("wr_done_pulses", dc, 1);
    chk("wr_ack_err", {31'd0, ack_err}, 32'd0);
    chk("wr_starts", n_starts, 1);
    chk("wr_stops", n_stops, 1);
    chk("wr_idle_scl", {31'd0, scl}, 32'd1);
    chk("wr_idle_oe", {31'd0, sda_oe}, 32'd0);

    // register read
    run_txn(1'b1, 7'h28, 8'h01, 8'h00, -1, bc, dc);
    check_bytes("rd", 3, 32'h00500151);
    chk("rd_rdata", {24'd0, rdata}, 32'hA5);
    chk("rd_busy_cycles", bc, 616);
    chk("rd_done_pulses", dc, 1);
    chk("rd_ack_err", {31'd0, ack_err}, 32'd0);
    chk("rd_starts", n_starts, 2);
    chk("rd_master_nack", {31'd0, master_ack}, 32'd1);
    chk("rd_stops", n_stops, 1);

    // address NACK (no slave)
    slave_present = 1'b0;
    run_txn(1'b0, 7'h28, 8'h03, 8'h5A, -1, bc, dc);
    check_bytes("nack", 1, 32'h00000050);
    chk("nack_ack_err", {31'd0, ack_err}, 32'd1);
    chk("nack_busy_cycles", bc, 168);
    chk("nack_rdata_kept", {24'd0, rdata}, 32'hA5);
    chk("nack_stops", n_stops, 1);
    chk("nack_done_pulses", dc, 1);

    // start while busy is ignored
    slave_present = 1'b1;
    run_txn(1'b0, 7'h28, 8'h07, 8'h3C, 100, bc, dc);
    check_bytes("sb", 3, 32'h0050073C);
    chk("sb_busy_cycles", bc, 456);
    chk("sb_done_pulses", dc, 1);
    chk("sb_ack_err_cleared", {31'd0, ack_err}, 32'd0);

    // reset during reg_addr byte
    @(negedge clk);
    rw = 1'b0; dev_addr = 7'h28; reg_addr = 8'hC3; wdata = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    for (int i = 0; i < 8 && scl !== 1'b0; i++) @(negedge clk);
    chk("mid_pre_scl_low", {31'd0, scl}, 32'd0);
    chk("mid_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_scl", {31'd0, scl}, 32'd1);
    chk("mid_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_txn(1'b0, 7'h28, 8'h03, 8'h5A, -1, bc, dc);
    check_bytes("after", 3, 32'h0050035A);
    chk("after_busy_cycles", bc, 456);
    chk("after_done_pulses", dc, 1);
    chk("after_ack_err", {31'd0, ack_err}, 32'd0);

    chk("done_busy_exclusive", both_high, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
